// File: rtl/umi_tx_arbiter_if.sv
// UMI request bundle: LANES parallel valid/ready channels with packed payload.
// The master drives valid and payload; the slave returns ready.
interface umi_tx_arbiter_if #(
    parameter int LANES = 1,
    parameter int DW    = 256,
    parameter int AW    = 64,
    parameter int CW    = 32
);
    logic [LANES-1:0]    valid;
    logic [LANES-1:0]    ready;
    logic [LANES*CW-1:0] cmd;
    logic [LANES*AW-1:0] dstaddr;
    logic [LANES*AW-1:0] srcaddr;
    logic [LANES*DW-1:0] data;

    modport master (output valid, cmd, dstaddr, srcaddr, data, input ready);
    modport slave  (input valid, cmd, dstaddr, srcaddr, data, output ready);
endinterface

// File: rtl/umi_tx_arbiter.sv
// Round-robin arbiter sharing one UMI TX port between N requesters, with a
// one-entry registered output stage and optional grant lock until the EOM beat.
module umi_tx_arbiter #(
    parameter int N        = 2,
    parameter int DW       = 256,
    parameter int AW       = 64,
    parameter int CW       = 32,
    parameter bit EOM_LOCK = 1'b1
) (
    input  logic             clk,
    input  logic             nreset,
    umi_tx_arbiter_if.slave  in,
    umi_tx_arbiter_if.master out
);
    localparam int IW      = $clog2(N);
    localparam int EOM_BIT = 22;

    logic [IW-1:0] ptr_q;
    logic          lock_q;
    logic [IW-1:0] lock_idx_q;

    logic          out_valid_q;
    logic [CW-1:0] out_cmd_q;
    logic [AW-1:0] out_dstaddr_q;
    logic [AW-1:0] out_srcaddr_q;
    logic [DW-1:0] out_data_q;

    logic          load;
    logic [N-1:0]  elig;
    logic          have_win;
    logic [IW-1:0] win;
    logic [IW-1:0] idx;
    logic          grant;
    logic          accept;

    logic [CW-1:0] sel_cmd;
    logic [AW-1:0] sel_dstaddr;
    logic [AW-1:0] sel_srcaddr;
    logic [DW-1:0] sel_data;

    assign load = !out_valid_q || out.ready;

    // While locked, only the lock holder is eligible, whether or not it is valid.
    assign elig = lock_q ? ({{(N-1){1'b0}}, 1'b1} << lock_idx_q) : in.valid;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        have_win = 1'b0;
        win      = '0;
        idx      = '0;
        for (int k = 1; k <= N; k++) begin
            idx = IW'((int'(ptr_q) + k) % N);
            if (!have_win && elig[idx]) begin
                have_win = 1'b1;
                win      = idx;
            end
        end
    end

    assign grant  = nreset && load && have_win;
    assign accept = grant && in.valid[win];

    always_comb begin
        in.ready        = '0;
        in.ready[win]   = grant;
    end

    always_comb begin
        sel_cmd     = '0;
        sel_dstaddr = '0;
        sel_srcaddr = '0;
        sel_data    = '0;
        for (int i = 0; i < N; i++) begin
            if (win == IW'(i)) begin
                sel_cmd     = in.cmd[i*CW +: CW];
                sel_dstaddr = in.dstaddr[i*AW +: AW];
                sel_srcaddr = in.srcaddr[i*AW +: AW];
                sel_data    = in.data[i*DW +: DW];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            // NOTE: the payload register is reset too, so a dropped beat never reappears after reset.
            out_valid_q   <= 1'b0;
            out_cmd_q     <= '0;
            out_dstaddr_q <= '0;
            out_srcaddr_q <= '0;
            out_data_q    <= '0;
            ptr_q         <= IW'(N - 1);
            lock_q        <= 1'b0;
            lock_idx_q    <= '0;
        end else if (accept) begin
            out_valid_q   <= 1'b1;
            out_cmd_q     <= sel_cmd;
            out_dstaddr_q <= sel_dstaddr;
            out_srcaddr_q <= sel_srcaddr;
            out_data_q    <= sel_data;
            ptr_q         <= win;
            if (EOM_LOCK) begin
                lock_q     <= ~sel_cmd[EOM_BIT];
                lock_idx_q <= win;
            end
        end else if (out.ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out.valid   = out_valid_q;
    assign out.cmd     = out_cmd_q;
    assign out.dstaddr = out_dstaddr_q;
    assign out.srcaddr = out_srcaddr_q;
    assign out.data    = out_data_q;
endmodule
